// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN frame sequencer: FSM state encodings and width helpers.
package bnn_pkg;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  // Guarded $clog2 so degenerate parameter values still give a legal 1-bit vector.
  function automatic int safeClog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  function automatic int predWidth(input int classCnt);
    return safeClog2(classCnt);
  endfunction

  function automatic int idxWidth(input int featCnt);
    return safeClog2(featCnt);
  endfunction

  function automatic int cntWidth(input int latency);
    return safeClog2(latency + 1);
  endfunction

endpackage

// File: rtl/bnn_frame_sequencer.sv
// Gathers serial feature beats into a packed frame, holds it for the BNN latency,
// samples the prediction and returns it on a valid/ready output.
module bnn_frame_sequencer
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT  = 11,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 7,
  parameter int LATENCY   = 48,
  localparam int PW       = predWidth(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_feat,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [PW-1:0]                 bnn_prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PW-1:0]                 out_prediction,
  output logic                          frame_err,
  output logic [15:0]                   frame_cnt
);

  localparam int IW = idxWidth(FEAT_CNT);
  localparam int CW = cntWidth(LATENCY);
  localparam logic [IW-1:0] LAST_IDX = IW'(FEAT_CNT - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(LATENCY - 1);

  logic [1:0]                   state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [FEAT_BITS-1:0]         shadow_q [FEAT_CNT];
  logic [FEAT_BITS-1:0]         shadow_d [FEAT_CNT];
  logic [FEAT_CNT*FEAT_BITS-1:0] shadowFlat;
  logic [FEAT_CNT*FEAT_BITS-1:0] features_q, features_d;
  logic [PW-1:0]                pred_q, pred_d;
  logic                         err_q, err_d;
  logic [15:0]                  frame_cnt_q, frame_cnt_d;
  logic                         accept;
  logic                         loadAccept;

  assign in_ready   = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign out_valid  = (state_q == ST_EMIT);
  assign accept     = in_valid && in_ready;
  assign loadAccept = accept && (state_q == ST_LOAD);

  // Shadow slot write is one-hot on idx; the flat view includes the beat being
  // accepted so the final beat lands in features on the same edge.
  always_comb begin
    shadowFlat = '0;
    for (int i = 0; i < FEAT_CNT; i++) begin
      shadow_d[i] = (loadAccept && (idx_q == IW'(i))) ? in_feat : shadow_q[i];
      shadowFlat[i*FEAT_BITS +: FEAT_BITS] = shadow_d[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    features_d  = features_q;
    pred_d      = pred_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (in_last) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) begin
              features_d = shadowFlat;
              cnt_d      = '0;
              state_d    = ST_RUN;
            end else begin
              err_d = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (accept && in_last) begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_END) begin
          pred_d  = bnn_prediction;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      features_q  <= '0;
      pred_q      <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < FEAT_CNT; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      features_q  <= features_d;
      pred_q      <= pred_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      for (int i = 0; i < FEAT_CNT; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign features       = features_q;
  assign out_prediction = pred_q;
  assign frame_err      = err_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_bnn_frame_sequencer.sv
// Scoreboard bench for bnn_frame_sequencer driven by a stub BNN with a programmable prediction.
module tb_bnn_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_feat;
  logic        in_last;
  logic [43:0] features;
  logic [2:0]  stubPred;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_prediction;
  logic        frame_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  bnn_frame_sequencer #(
    .FEAT_CNT(11), .FEAT_BITS(4), .CLASS_CNT(7), .LATENCY(48)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat), .in_last(in_last),
    .features(features), .bnn_prediction(stubPred),
    .out_valid(out_valid), .out_ready(out_ready), .out_prediction(out_prediction),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [2:0]  pred;
    logic [15:0] cntAfter;
  } expT;

  expT         expQ[$];
  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  int          handshakes = 0;
  int          errPulses = 0;
  int          firstValidCycle = -1;
  logic        prevValid = 1'b0;
  logic        cntCheckPending = 1'b0;
  logic [15:0] cntCheckVal = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic [2:0] pred, input logic [15:0] cntAfter);
    expT e;
    e.pred     = pred;
    e.cntAfter = cntAfter;
    expQ.push_back(e);
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: pops the scoreboard on every output handshake and checks the
  // frame counter on the following cycle.
  always @(negedge clk) begin
    expT e;
    if (cntCheckPending) begin
      checkOutput("frame_cnt after handshake", 64'(frame_cnt), 64'(cntCheckVal));
      cntCheckPending = 1'b0;
    end
    if (out_valid && !prevValid) firstValidCycle = cycle;
    prevValid = out_valid;
    if (frame_err) errPulses++;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected result: got prediction 0x%0h, wanted no output", out_prediction);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_prediction", 64'(out_prediction), 64'(e.pred));
        cntCheckVal     = e.cntAfter;
        cntCheckPending = 1'b1;
        handshakes++;
      end
    end
  end

  task automatic sendBeat(input logic [3:0] f, input logic l, output int beatCycle);
    int guard;
    in_valid  = 1'b1;
    in_feat   = f;
    in_last   = l;
    guard     = 0;
    beatCycle = -1;
    while (1) begin
      @(negedge clk);
      if (in_ready || guard > 500) break;
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL beat accept timeout: got in_ready=0, wanted 1");
    end else begin
      beatCycle = cycle;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n, input logic [3:0] base, input logic [3:0] step,
                               input int lastAt, input bit hold, output int lastCycle);
    logic [3:0] v;
    int c;
    v = base;
    lastCycle = -1;
    for (int i = 0; i < n; i++) begin
      sendBeat(v, (i + 1) == lastAt, c);
      lastCycle = c;
      v = v + step;
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic waitHandshake(input int target);
    int g;
    g = 0;
    while (handshakes < target && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("handshake count", 64'(handshakes), 64'(target));
  endtask

  task automatic waitValid();
    int g;
    g = 0;
    while (!out_valid && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput("out_valid reached", 64'(out_valid), 64'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, wanted $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lastCycle;
    int c;
    int errBase;
    logic [3:0] v;

    rst = 1'b1; in_valid = 1'b0; in_feat = '0; in_last = 1'b0;
    out_ready = 1'b1; stubPred = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset features", 64'(features), 64'(0));
    checkOutput("reset frame_cnt", 64'(frame_cnt), 64'(0));
    checkOutput("reset out_prediction", 64'(out_prediction), 64'(0));
    checkOutput("reset frame_err", 64'(frame_err), 64'(0));
    @(posedge clk); #1;

    // Basic frame 1..B, downstream always ready.
    stubPred = 3'd2;
    pushExpect(3'd2, 16'd1);
    applyStimulus(11, 4'h1, 4'h1, 11, 1'b0, lastCycle);
    waitHandshake(1);
    checkOutput("features frame1", 64'(features), 64'(44'hBA987654321));
    checkOutput("last beat to out_valid cycles", 64'(firstValidCycle - lastCycle), 64'(49));

    // Backpressure in EMIT: result held while out_ready is low.
    out_ready = 1'b0;
    stubPred  = 3'd5;
    pushExpect(3'd5, 16'd2);
    applyStimulus(11, 4'h1, 4'h1, 11, 1'b0, lastCycle);
    @(negedge clk);
    checkOutput("in_ready during RUN", 64'(in_ready), 64'(0));
    waitValid();
    stubPred = 3'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("held out_valid", 64'(out_valid), 64'(1));
      checkOutput("held out_prediction", 64'(out_prediction), 64'(5));
      checkOutput("in_ready during EMIT", 64'(in_ready), 64'(0));
    end
    checkOutput("frame_cnt before release", 64'(frame_cnt), 64'(1));
    @(posedge clk); #1 out_ready = 1'b1;
    waitHandshake(2);
    repeat (4) @(negedge clk);
    checkOutput("single increment on release", 64'(frame_cnt), 64'(2));
    checkOutput("in_ready after EMIT", 64'(in_ready), 64'(1));

    // Short frame: in_last on beat 4.
    errBase = errPulses;
    applyStimulus(4, 4'hC, 4'h1, 4, 1'b0, lastCycle);
    repeat (5) @(negedge clk);
    checkOutput("short frame_err pulses", 64'(errPulses - errBase), 64'(1));
    checkOutput("short features unchanged", 64'(features), 64'(44'hBA987654321));
    checkOutput("short no output", 64'(handshakes), 64'(2));
    @(posedge clk); #1;
    stubPred = 3'd3;
    pushExpect(3'd3, 16'd3);
    applyStimulus(11, 4'hF, 4'hF, 11, 1'b0, lastCycle);
    waitHandshake(3);
    checkOutput("features after short", 64'(features), 64'(44'h56789ABCDEF));

    // Long frame: 14 beats, in_last on beat 14.
    errBase = errPulses;
    applyStimulus(14, 4'h0, 4'h1, 14, 1'b0, lastCycle);
    repeat (5) @(negedge clk);
    checkOutput("long frame_err pulses", 64'(errPulses - errBase), 64'(1));
    checkOutput("long frame_cnt unchanged", 64'(frame_cnt), 64'(3));
    checkOutput("long features unchanged", 64'(features), 64'(44'h56789ABCDEF));
    checkOutput("long back in LOAD", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Reset 20 cycles into RUN: result lost, counter cleared.
    stubPred = 3'd4;
    applyStimulus(11, 4'h3, 4'h2, 11, 1'b0, lastCycle);
    repeat (19) @(posedge clk);
    @(negedge clk);
    checkOutput("features before reset", 64'(features), 64'(44'h7531FDB9753));
    checkOutput("no output mid RUN", 64'(out_valid), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("post-reset features", 64'(features), 64'(0));
    checkOutput("post-reset frame_cnt", 64'(frame_cnt), 64'(0));
    checkOutput("post-reset in_ready", 64'(in_ready), 64'(1));
    repeat (60) @(negedge clk);
    checkOutput("lost result not emitted", 64'(handshakes), 64'(3));

    // Wrap frame_cnt and run two frames back to back with in_valid held high.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    @(negedge clk);
    checkOutput("preloaded frame_cnt", 64'(frame_cnt), 64'(16'hFFFF));
    @(posedge clk); #1;
    stubPred = 3'd6;
    pushExpect(3'd6, 16'h0000);
    pushExpect(3'd7, 16'h0001);
    applyStimulus(11, 4'hA, 4'h3, 11, 1'b1, lastCycle);
    v = 4'h7;
    sendBeat(v, 1'b0, c);
    stubPred = 3'd7;
    for (int i = 1; i < 11; i++) begin
      v = v + 4'h5;
      sendBeat(v, i == 10, c);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitHandshake(5);
    repeat (2) @(negedge clk);
    checkOutput("back-to-back features", 64'(features), 64'(44'h94FA50B61C7));
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
